// File: rtl/mag_tape_seq.sv
// Magnetic tape unit motion sequencer.
// Decodes a motion command from the source field, accelerates the
// selected unit and holds it at speed. It always decelerates before any
// restart or direction change, and flags end-of-tape with a sticky error.
module mag_tape_seq #(
    parameter int unsigned N_UNITS   = 4,
    parameter int unsigned START_CYC = 16,
    parameter int unsigned STOP_CYC  = 8,
    parameter int unsigned UW        = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               DS,
    input  logic               S0,
    input  logic               S1,
    input  logic               S3,
    input  logic               S7,
    input  logic               SU,
    input  logic               SV,
    input  logic               SW,
    input  logic               CX,
    input  logic               CW,
    input  logic [UW-1:0]      UNIT,
    input  logic [N_UNITS-1:0] TAPE_END,
    output logic               CIR_1,
    output logic               CIR_2,
    output logic               CIR_3,
    output logic               CIR_4,
    output logic [N_UNITS-1:0] MAG_TAPE_FWD,
    output logic [N_UNITS-1:0] MAG_TAPE_REV,
    output logic               MAG6_OUT,
    output logic               READY,
    output logic               BUSY,
    output logic               ERR
);

    localparam int unsigned MAX_CYC = (START_CYC > STOP_CYC) ? START_CYC : STOP_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(STOP_CYC - 1);
    localparam logic [UW:0]      UNIT_LIM = (UW + 1)'(N_UNITS);

    typedef enum logic [1:0] {StIdle, StAccel, StRun, StDecel} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               dir;      // 0 = forward, 1 = reverse
    logic [UW-1:0]      unit_q;

    logic               rq_fwd, rq_rev, rq_wr, req_ok, end_hit, stop_req;
    logic [N_UNITS-1:0] sel_new, sel_cur;

    // Source-field decode and per-unit select masks.
    always_comb begin
        rq_fwd   = (DS & SV & (S1 | S3)) | (DS & SW & S0);
        rq_rev   = DS & SU & S1;
        rq_wr    = DS & SW & S7;
        // Conflicting fwd+rev reads as no request at all.
        req_ok   = rq_fwd ^ rq_rev;
        end_hit  = TAPE_END[unit_q];
        stop_req = end_hit | ~req_ok | (rq_rev != dir);
        sel_new  = N_UNITS'(1) << UNIT;
        sel_cur  = N_UNITS'(1) << unit_q;
    end

    // Sequencer FSM with registered drive/status outputs.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state        <= StIdle;
            cnt          <= '0;
            dir          <= 1'b0;
            unit_q       <= '0;
            MAG_TAPE_FWD <= '0;
            MAG_TAPE_REV <= '0;
            MAG6_OUT     <= 1'b0;
            READY        <= 1'b0;
            BUSY         <= 1'b0;
            ERR          <= 1'b0;
            CIR_1        <= 1'b0;
            CIR_2        <= 1'b0;
            CIR_3        <= 1'b0;
            CIR_4        <= 1'b0;
        end else begin
            CIR_1 <= CW & ~CX;
            CIR_2 <= CX & ~CW;
            CIR_3 <= CX & CW;
            CIR_4 <= ~CX & ~CW;

            // Drives are off unless a branch below re-asserts them.
            MAG_TAPE_FWD <= '0;
            MAG_TAPE_REV <= '0;
            MAG6_OUT     <= 1'b0;
            READY        <= 1'b0;
            BUSY         <= 1'b1;

            unique case (state)
                StIdle: begin
                    BUSY <= 1'b0;
                    if (req_ok) begin
                        if ({1'b0, UNIT} >= UNIT_LIM) begin
                            ERR <= 1'b1;
                        end else begin
                            state        <= StAccel;
                            dir          <= rq_rev;
                            unit_q       <= UNIT;
                            cnt          <= START_LD;
                            ERR          <= 1'b0;
                            BUSY         <= 1'b1;
                            MAG_TAPE_FWD <= rq_rev ? '0 : sel_new;
                            MAG_TAPE_REV <= rq_rev ? sel_new : '0;
                        end
                    end
                end
                StAccel, StRun: begin
                    if (stop_req) begin
                        state <= StDecel;
                        cnt   <= STOP_LD;
                        if (end_hit) begin
                            ERR <= 1'b1;
                        end
                    end else begin
                        MAG_TAPE_FWD <= dir ? '0 : sel_cur;
                        MAG_TAPE_REV <= dir ? sel_cur : '0;
                        if (state == StRun || cnt == '0) begin
                            state    <= StRun;
                            READY    <= 1'b1;
                            MAG6_OUT <= ~dir & rq_wr;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                StDecel: begin
                    if (cnt == '0) begin
                        state <= StIdle;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_tape_seq.sv
// Bench for mag_tape_seq: cycle model plus directed literal checks.
module tb_mag_tape_seq;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int TC = 2;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic DS = 0, S0 = 0, S1 = 0, S3 = 0, S7 = 0, SU = 0, SV = 0, SW = 0, CX = 0, CW = 0;
    logic [1:0] UNIT = '0;
    logic [3:0] TAPE_END = '0;
    logic c1, c2, c3, c4, mag6, ready, busy, err;
    logic [3:0] fwd, rev;

    // Auxiliary instances for non-power-of-two unit counts.
    logic [2:0] unit6 = '0;
    logic [5:0] te6 = '0, fwd6, rev6;
    logic a6_c1, a6_c2, a6_c3, a6_c4, mag6_6, ready6, busy6, err6;
    logic [1:0] unit3 = '0;
    logic [2:0] te3 = '0, fwd3, rev3;
    logic a3_c1, a3_c2, a3_c3, a3_c4, mag6_3, ready3, busy3, err3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mag_tape_seq #(.N_UNITS(N), .START_CYC(SC), .STOP_CYC(TC)) u_dut (
        .CLK(CLK), .rst_n(rst_n), .DS(DS), .S0(S0), .S1(S1), .S3(S3), .S7(S7),
        .SU(SU), .SV(SV), .SW(SW), .CX(CX), .CW(CW), .UNIT(UNIT), .TAPE_END(TAPE_END),
        .CIR_1(c1), .CIR_2(c2), .CIR_3(c3), .CIR_4(c4), .MAG_TAPE_FWD(fwd),
        .MAG_TAPE_REV(rev), .MAG6_OUT(mag6), .READY(ready), .BUSY(busy), .ERR(err)
    );

    mag_tape_seq #(.N_UNITS(6), .START_CYC(SC), .STOP_CYC(TC)) u_dut6 (
        .CLK(CLK), .rst_n(rst_n), .DS(DS), .S0(S0), .S1(S1), .S3(S3), .S7(S7),
        .SU(SU), .SV(SV), .SW(SW), .CX(CX), .CW(CW), .UNIT(unit6), .TAPE_END(te6),
        .CIR_1(a6_c1), .CIR_2(a6_c2), .CIR_3(a6_c3), .CIR_4(a6_c4), .MAG_TAPE_FWD(fwd6),
        .MAG_TAPE_REV(rev6), .MAG6_OUT(mag6_6), .READY(ready6), .BUSY(busy6), .ERR(err6)
    );

    mag_tape_seq #(.N_UNITS(3), .START_CYC(SC), .STOP_CYC(TC)) u_dut3 (
        .CLK(CLK), .rst_n(rst_n), .DS(DS), .S0(S0), .S1(S1), .S3(S3), .S7(S7),
        .SU(SU), .SV(SV), .SW(SW), .CX(CX), .CW(CW), .UNIT(unit3), .TAPE_END(te3),
        .CIR_1(a3_c1), .CIR_2(a3_c2), .CIR_3(a3_c3), .CIR_4(a3_c4), .MAG_TAPE_FWD(fwd3),
        .MAG_TAPE_REV(rev3), .MAG6_OUT(mag6_3), .READY(ready3), .BUSY(busy3), .ERR(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: motion tracked as "cycles since start" and
    // "stop cycles remaining" rather than as named states.
    bit m_valid = 0, m_act = 0, m_dir = 0, m_err = 0, m_wr = 0, m_rst = 1;
    bit m_cx = 0, m_cw = 0, rf, rr;
    int m_el = 0, m_stop = 0, m_unit = 0;

    always @(posedge CLK) begin
        rf = DS && ((SV && (S1 || S3)) || (SW && S0));
        rr = DS && SU && S1;
        if (!rst_n) begin
            m_valid = 1; m_rst = 1; m_act = 0; m_dir = 0; m_err = 0; m_wr = 0;
            m_el = 0; m_stop = 0; m_unit = 0;
        end else begin
            m_rst = 0; m_cx = CX; m_cw = CW;
            m_wr = DS && SW && S7;
            if (m_stop > 0) begin
                m_stop--;
            end else if (m_act) begin
                if (TAPE_END[m_unit]) begin
                    m_err = 1; m_act = 0; m_stop = TC;
                end else if (rf == rr || rr != m_dir) begin
                    m_act = 0; m_stop = TC;
                end else if (m_el < SC) begin
                    m_el++;
                end
            end else if (rf != rr) begin
                if (int'(UNIT) >= N) begin
                    m_err = 1;
                end else begin
                    m_act = 1; m_el = 0; m_dir = rr; m_unit = int'(UNIT); m_err = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            logic [3:0] e_sel, e_cir;
            logic e_run;
            e_sel = m_act ? (4'b0001 << m_unit) : 4'b0000;
            e_run = m_act && (m_el >= SC);
            e_cir = m_rst ? 4'b0000 : {~m_cx & ~m_cw, m_cx & m_cw, m_cx & ~m_cw, m_cw & ~m_cx};
            check("m_fwd", 32'(fwd), 32'(m_dir ? 4'b0 : e_sel));
            check("m_rev", 32'(rev), 32'(m_dir ? e_sel : 4'b0));
            check("m_ready", 32'(ready), 32'(e_run));
            check("m_busy", 32'(busy), 32'(m_act || (m_stop > 0)));
            check("m_err", 32'(err), 32'(m_err));
            check("m_mag6", 32'(mag6), 32'(e_run && !m_dir && m_wr));
            check("m_cir", 32'({c4, c3, c2, c1}), 32'(e_cir));
            check("m_onehot", 32'($countones(fwd | rev) <= 1), 32'(1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic [1:0] cir_in [4] = '{2'b00, 2'b01, 2'b10, 2'b11};  // {CX, CW}
    logic [3:0] cir_exp [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};  // {c4..c1}

    initial begin
        // Reset state
        step(2);
        check("rst_drv", 32'({fwd, rev}), 32'(0));
        check("rst_stat", 32'({ready, busy, err, mag6}), 32'(0));
        check("rst_cir", 32'({c4, c3, c2, c1}), 32'(0));
        rst_n = 1;

        // Characteristic decode, one cycle latency
        for (int i = 0; i < 4; i++) begin
            {CX, CW} = cir_in[i];
            step(1);
            check("cir", 32'({c4, c3, c2, c1}), 32'(cir_exp[i]));
        end

        // Forward on unit 2; UNIT change while running is ignored
        DS = 1; SV = 1; S1 = 1; UNIT = 2;
        step(1);
        check("fwd_start", 32'(fwd), 32'(4'b0100));
        check("fwd_busy", 32'({busy, ready, rev}), 32'({1'b1, 1'b0, 4'b0}));
        UNIT = 0;
        step(3);
        check("fwd_accel", 32'({ready, fwd}), 32'({1'b0, 4'b0100}));
        step(1);
        check("fwd_ready", 32'(ready), 32'(1));

        // Write gate then stop
        SW = 1; S7 = 1;
        step(1);
        check("wr_gate", 32'(mag6), 32'(1));
        DS = 0;
        step(1);
        check("stop1", 32'({fwd, ready, busy, mag6}), 32'({4'b0, 1'b0, 1'b1, 1'b0}));
        step(1);
        check("stop2", 32'(busy), 32'(1));
        step(1);
        check("stop_idle", 32'(busy), 32'(0));
        SW = 0; S7 = 0;

        // Reversal interlock
        DS = 1; SV = 1; S1 = 1; UNIT = 2;
        step(5);
        check("rv_run", 32'(ready), 32'(1));
        SV = 0; SU = 1;
        step(1);
        check("rv_dec1", 32'({fwd, rev, busy}), 32'({4'b0, 4'b0, 1'b1}));
        step(1);
        check("rv_dec2", 32'({fwd, rev, busy}), 32'({4'b0, 4'b0, 1'b1}));
        step(1);
        check("rv_idle", 32'({rev, busy}), 32'(0));
        step(1);
        check("rv_start", 32'({rev, ready}), 32'({4'b0100, 1'b0}));
        step(3);
        check("rv_accel", 32'(ready), 32'(0));
        step(1);
        check("rv_ready", 32'(ready), 32'(1));

        // End of tape: other unit ignored, own unit forces stop and sticky ERR
        TAPE_END = 4'b0001;
        step(1);
        check("eot_other", 32'({ready, err}), 32'({1'b1, 1'b0}));
        TAPE_END = 4'b0100;
        step(1);
        check("eot_hit", 32'({err, busy, rev}), 32'({1'b1, 1'b1, 4'b0}));
        TAPE_END = 4'b0000; DS = 0;
        step(4);
        check("eot_hold", 32'({err, busy}), 32'({1'b1, 1'b0}));
        DS = 1; SU = 0; SV = 1; UNIT = 1;
        step(1);
        check("eot_clear", 32'({err, fwd}), 32'({1'b0, 4'b0010}));

        // Conflicting fwd+rev is no request
        DS = 0;
        step(3);
        DS = 1; SU = 1;
        step(2);
        check("conflict", 32'({busy, fwd, rev}), 32'(0));
        DS = 0; SU = 0;

        // Unit range on 6- and 3-unit builds
        rst_n = 0;
        step(1);
        rst_n = 1; unit6 = 5; unit3 = 3; UNIT = 1; DS = 1; SV = 1; S1 = 1;
        step(1);
        check("u6_fwd", 32'({fwd6, busy6}), 32'({6'b100000, 1'b1}));
        check("u3_ref", 32'({err3, busy3, fwd3}), 32'({1'b1, 1'b0, 3'b0}));

        // Reset mid-run drops everything at once
        step(4);
        check("rr_run", 32'(ready), 32'(1));
        rst_n = 0;
        step(1);
        check("rr_out", 32'({fwd, rev, ready, busy, err, mag6}), 32'(0));
        check("rr_aux", 32'({err3, busy6, fwd6}), 32'(0));
        rst_n = 1;
        step(1);
        check("rr_restart", 32'({fwd, busy}), 32'({4'b0010, 1'b1}));
        DS = 0;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
